// File: rtl/line_pkg.sv
// ---------------------------------------------------------------------------
// line_pkg
// Shared widths, types and helpers for the oblique line renderer.
//   XW / YW       : raster column / row widths
//   AW            : signed width of the Bresenham arithmetic
//   rgb_t         : 24-bit pixel colour
//   span_t        : x-span of line pixels on one row {valid, lo, hi}
//   step_state_e  : stepper FSM states
// ---------------------------------------------------------------------------
package line_pkg;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int AW = 13;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        logic          valid;
        logic [XW-1:0] lo;
        logic [XW-1:0] hi;
    } span_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP,
        WAIT,
        DONE
    } step_state_e;

    localparam span_t SPAN_EMPTY = '{valid: 1'b0, lo: '0, hi: '0};

    // Grow a span so it also covers column x; an empty span becomes [x, x].
    function automatic span_t span_extend(span_t s, logic [XW-1:0] x);
        span_t r;
        r.valid = 1'b1;
        r.lo    = (!s.valid || x < s.lo) ? x : s.lo;
        r.hi    = (!s.valid || x > s.hi) ? x : s.hi;
        return r;
    endfunction

endpackage

// File: rtl/bresenham_stepper.sv
// ---------------------------------------------------------------------------
// bresenham_stepper
// Walks a Bresenham line one row ahead of the raster and accumulates the
// x-span of line pixels for the next row to be displayed.
//   clk, rst_n      : pixel clock, asynchronous active-low reset
//   x_cnt_i/y_cnt_i : raster position from the XY counter
//   x0_i,y0_i       : first endpoint  (sampled only at the latch point)
//   x1_i,y1_i       : second endpoint (sampled only at the latch point)
//   commit_o        : row boundary; the consumer loads span_next_o now
//   span_next_o     : span for the row that starts after the next boundary
// Endpoints are captured on the boundary entering the last row, so the
// stepper uses that row to produce row 0 of the following frame.
// ---------------------------------------------------------------------------
module bresenham_stepper
    import line_pkg::*;
#(
    parameter int H_LINE = 20,
    parameter int V_LINE = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [XW-1:0] x_cnt_i,
    input  logic [YW-1:0] y_cnt_i,
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW-1:0] x1_i,
    input  logic [YW-1:0] y1_i,
    output logic          commit_o,
    output span_t         span_next_o
);

    // Clamping x to H_LINE-3 keeps a fully horizontal row within the
    // cycles available between two row boundaries.
    localparam logic [XW-1:0] X_MAX   = XW'(H_LINE - 3);
    localparam logic [YW-1:0] Y_MAX   = YW'(V_LINE - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(H_LINE - 1);
    localparam logic [YW-1:0] Y_LATCH = YW'(V_LINE - 2);
    localparam logic signed [AW-1:0] S_ONE = AW'(1);

    step_state_e          state_q, state_d;
    logic [XW-1:0]        xa_q, xa_d, xb_q, xb_d;
    logic [YW-1:0]        ya_q, ya_d, yb_q, yb_d;
    logic signed [AW-1:0] px_q, px_d, py_q, py_d;
    logic signed [AW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d;
    logic [YW-1:0]        next_row_q, next_row_d;
    span_t                span_q, span_d;

    logic                 rb, latch;
    logic [XW-1:0]        x0_c, x1_c;
    logic [YW-1:0]        y0_c, y1_c;
    logic signed [AW-1:0] xa_s, xb_s, ya_s, yb_s, row_s;
    logic signed [AW-1:0] dx_c, dy_c, e2, err_n;
    logic                 at_end;

    assign rb    = (x_cnt_i == X_LAST);
    assign latch = rb && (y_cnt_i == Y_LATCH);

    assign x0_c = (x0_i > X_MAX) ? X_MAX : x0_i;
    assign x1_c = (x1_i > X_MAX) ? X_MAX : x1_i;
    assign y0_c = (y0_i > Y_MAX) ? Y_MAX : y0_i;
    assign y1_c = (y1_i > Y_MAX) ? Y_MAX : y1_i;

    assign xa_s  = $signed({2'b00, xa_q});
    assign xb_s  = $signed({2'b00, xb_q});
    assign ya_s  = $signed({3'b000, ya_q});
    assign yb_s  = $signed({3'b000, yb_q});
    assign row_s = $signed({3'b000, next_row_q});

    assign dx_c   = (xb_s < xa_s) ? (xa_s - xb_s) : (xb_s - xa_s);
    assign dy_c   = yb_s - ya_s;
    assign e2     = err_q <<< 1;
    assign at_end = (px_q == xb_s) && (py_q == yb_s);

    always_comb begin
        // NOTE: every _d starts from its current value so no path through this block infers a latch.
        state_d    = state_q;
        xa_d       = xa_q;
        ya_d       = ya_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        px_d       = px_q;
        py_d       = py_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sx_neg_d   = sx_neg_q;
        next_row_d = next_row_q;
        span_d     = span_q;
        err_n      = err_q;

        case (state_q)
            SETUP: begin
                px_d     = xa_s;
                py_d     = ya_s;
                dx_d     = dx_c;
                dy_d     = dy_c;
                sx_neg_d = (xb_s < xa_s);
                err_d    = dx_c - dy_c;
                state_d  = STEP;
            end
            STEP: begin
                if (py_q != row_s) begin
                    // Current point belongs to a later row: park until the boundary.
                    state_d = WAIT;
                end else begin
                    span_d = span_extend(span_q, px_q[XW-1:0]);
                    if (at_end) begin
                        state_d = DONE;
                    end else begin
                        // Both tests use the pre-step e2, as in textbook Bresenham.
                        if (e2 > -dy_q) begin
                            err_n = err_n - dy_q;
                            px_d  = sx_neg_q ? (px_q - S_ONE) : (px_q + S_ONE);
                        end
                        if (e2 < dx_q) begin
                            err_n = err_n + dx_q;
                            py_d  = py_q + S_ONE;
                        end
                        err_d = err_n;
                    end
                end
            end
            default: ;
        endcase

        // Every row boundary hands the accumulated span to the display side.
        if (rb) begin
            span_d = SPAN_EMPTY;
            if (state_q == WAIT) begin
                state_d    = STEP;
                next_row_d = next_row_q + YW'(1);
            end
        end

        // Latch wins over everything else; sorted so ya <= yb, ties keep point 0 first.
        if (latch) begin
            if (y1_c < y0_c) begin
                xa_d = x1_c;
                ya_d = y1_c;
                xb_d = x0_c;
                yb_d = y0_c;
            end else begin
                xa_d = x0_c;
                ya_d = y0_c;
                xb_d = x1_c;
                yb_d = y1_c;
            end
            next_row_d = '0;
            state_d    = SETUP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            xa_q       <= '0;
            ya_q       <= '0;
            xb_q       <= '0;
            yb_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            sx_neg_q   <= 1'b0;
            next_row_q <= '0;
            span_q     <= SPAN_EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values together.
            state_q    <= state_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            px_q       <= px_d;
            py_q       <= py_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            sx_neg_q   <= sx_neg_d;
            next_row_q <= next_row_d;
            span_q     <= span_d;
        end
    end

    assign commit_o    = rb;
    assign span_next_o = span_q;

endmodule

// File: rtl/oblique_line_render.sv
// ---------------------------------------------------------------------------
// oblique_line_render
// Paints one straight line between two endpoints over a background colour,
// driven by the XY raster counter. A Bresenham stepper prepares the next
// row's span; this module holds the span of the row being scanned, does the
// hit compare and registers the pixel outputs (1-cycle latency).
//   iCLK, iRST_n      : pixel clock, asynchronous active-low reset
//   x_cnt, y_cnt      : raster column / row from the counter
//   x_period/y_period : horizontal / vertical valid from the counter
//   iX0,iY0,iX1,iY1   : line endpoints (captured once per frame)
//   iLine_color       : line colour
//   iBg_color         : background colour
//   oRGB              : registered pixel colour
//   oHD, oVD          : x_period / y_period delayed one cycle
//   oLine_hit         : registered "pixel is on the line"
// Build option: define LINE_THICK_EN to widen each row span by one pixel on
// both sides (clamped to the row), giving a 3-pixel stroke on steep lines.
// ---------------------------------------------------------------------------
module oblique_line_render
    import line_pkg::*;
#(
    parameter int H_LINE = 20,
    parameter int V_LINE = 10
) (
    input  logic          iCLK,
    input  logic          iRST_n,
    input  logic [XW-1:0] x_cnt,
    input  logic [YW-1:0] y_cnt,
    input  logic          x_period,
    input  logic          y_period,
    input  logic [XW-1:0] iX0,
    input  logic [XW-1:0] iX1,
    input  logic [YW-1:0] iY0,
    input  logic [YW-1:0] iY1,
    input  rgb_t          iLine_color,
    input  rgb_t          iBg_color,
    output rgb_t          oRGB,
    output logic          oHD,
    output logic          oVD,
    output logic          oLine_hit
);

    localparam logic [XW-1:0] X_LAST = XW'(H_LINE - 1);

    logic          commit;
    span_t         span_next;
    span_t         span_cur_q, span_cur_d;
    logic [XW-1:0] lo_eff, hi_eff;
    logic          hit;
    rgb_t          rgb_q, rgb_d;
    logic          hd_q, vd_q, hit_q;

    bresenham_stepper #(
        .H_LINE (H_LINE),
        .V_LINE (V_LINE)
    ) u_stepper (
        .clk         (iCLK),
        .rst_n       (iRST_n),
        .x_cnt_i     (x_cnt),
        .y_cnt_i     (y_cnt),
        .x0_i        (iX0),
        .y0_i        (iY0),
        .x1_i        (iX1),
        .y1_i        (iY1),
        .commit_o    (commit),
        .span_next_o (span_next)
    );

    always_comb begin
        span_cur_d = commit ? span_next : span_cur_q;
`ifdef LINE_THICK_EN
        lo_eff = (span_cur_q.lo == '0)     ? '0     : (span_cur_q.lo - XW'(1));
        hi_eff = (span_cur_q.hi >= X_LAST) ? X_LAST : (span_cur_q.hi + XW'(1));
`else
        lo_eff = span_cur_q.lo;
        hi_eff = span_cur_q.hi;
`endif
        hit   = span_cur_q.valid && (x_cnt >= lo_eff) && (x_cnt <= hi_eff);
        rgb_d = hit ? iLine_color : iBg_color;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            span_cur_q <= SPAN_EMPTY;
            rgb_q      <= '0;
            hd_q       <= 1'b0;
            vd_q       <= 1'b1;
            hit_q      <= 1'b0;
        end else begin
            span_cur_q <= span_cur_d;
            rgb_q      <= rgb_d;
            hd_q       <= x_period;
            vd_q       <= y_period;
            hit_q      <= hit;
        end
    end

    assign oRGB      = rgb_q;
    assign oHD       = hd_q;
    assign oVD       = vd_q;
    assign oLine_hit = hit_q;

endmodule

// File: doc/oblique_line_render.md
Name: oblique_line_render

Overview:
- Downstream consumer of the XY raster counter: takes x_cnt/y_cnt/x_period/y_period and paints one straight line between two endpoints over a background colour.
- A Bresenham stepper computes, one row ahead, the x-span of line pixels for the next row. At each row boundary a per-row span register is swapped in.
- Output is registered RGB plus sync periods re-aligned by one cycle, feeding the LCD output stage.

Parameters:
- H_LINE, 20, counts per row; must equal the counter's H_LINE.
- V_LINE, 10, rows per frame; must equal the counter's V_LINE; must be ≥ 2.

Ports:
- iCLK  in  1  pixel clock
- iRST_n  in  1  reset
- x_cnt  in  11  raster column from counter
- y_cnt  in  10  raster row from counter
- x_period  in  1  horizontal valid from counter
- y_period  in  1  vertical valid from counter
- iX0,iX1  in  11  endpoint x coordinates
- iY0,iY1  in  10  endpoint y coordinates
- iLine_color  in  24  line RGB
- iBg_color  in  24  background RGB
- oRGB  out  24  pixel colour
- oHD  out  1  x_period delayed 1 cycle
- oVD  out  1  y_period delayed 1 cycle
- oLine_hit  out  1  current pixel is on the line

Interface rule (already decided): one clock, iCLK; reset iRST_n is asynchronous, active-low.

Behaviour:
- Reset values: oRGB=0, oHD=0, oVD=1, oLine_hit=0; FSM=IDLE; span_cur and span_next empty.
- Row boundary (rb) is defined as x_cnt==H_LINE-1.
- Endpoint latch: occurs on rb with y_cnt==V_LINE-2, i.e. on entry to the last row.
  - Endpoints are sorted so that ya ≤ yb; equal y keeps the iX0 point first.
  - x is clamped to H_LINE-3 and y to V_LINE-1.
  - next_row is set to 0.
  - Input changes at any other time are ignored until the next latch.
- Stepper setup (SETUP, 1 cycle) computes:
  - dx = |xb-xa|, dy = yb-ya, sx = ±1, err = dx-dy.
  - All arithmetic is 13-bit signed.
  - Point (px,py) = (xa,ya).
- Stepper FSM states: IDLE, SETUP, STEP, WAIT, DONE.
  - IDLE→SETUP on latch.
  - SETUP→STEP.
  - STEP handles one Bresenham step per cycle while py==next_row:
    - span_next.lo=min(lo,px), hi=max(hi,px), valid=1.
    - If (px,py)==(xb,yb) → DONE.
    - Otherwise e2=2·err; if e2>-dy then err-=dy, px+=sx; if e2<dx then err+=dx, py+=1.
  - STEP→WAIT when py≠next_row, or when next_row<ya (span_next empty).
  - WAIT→STEP on rb: span_cur←span_next, span_next←empty, next_row++.
  - DONE: on rb, span_cur←span_next and span_next←empty; stays in DONE until the next latch.
  - Latch from any state→SETUP; the pending span_next is still committed at that rb.
- Pixel path (1-cycle latency):
  - hit = span_cur.valid && lo≤x_cnt≤hi.
  - oLine_hit←hit; oRGB←hit?iLine_color:iBg_color; oHD←x_period; oVD←y_period.
- Step budget: the clamping guarantees that the worst-case row (horizontal line) finishes before the next rb.
- Single-point line (equal endpoints): one pixel.
- Reset mid-frame: everything returns to reset values; no line is drawn until the next latch.

Optional Feature:
- Macro LINE_THICK_EN.
- Defined: the hit test uses lo-1 … hi+1, clamped to 0 and H_LINE-1, giving a 3-pixel-wide stroke on steep lines.
- Undefined: exact Bresenham span as above.

Decomposition:
- Package line_pkg holds:
  - XW=11, YW=10 widths
  - rgb_t (24-bit)
  - span_t struct {valid, lo, hi}
  - stepper state enum
- Sub-module bresenham_stepper:
  - Contents: latch/sort/clamp, FSM, err arithmetic.
  - Output: span_next and its commit at rb.
  - The top module keeps span_cur, the hit compare and the output registers.

Test Plan (H_LINE=20, V_LINE=10, counter instantiated upstream):
- Reset held low → oRGB=0, oHD=0, oVD=1, oLine_hit=0.
- Vertical line (5,2)-(5,6) → next frame: oLine_hit=1 exactly one cycle after x_cnt==5 in rows 2–6; 5 hits per frame; oRGB=iLine_color on hits, iBg_color elsewhere.
- Horizontal line (3,4)-(12,4) → row 4 hits x 3..12 (10 pixels); no other row hits.
- Diagonal (0,0)-(9,9), then swapped (9,9)-(0,0) → row r hits only x=r in both cases; endpoint change mid-frame takes effect only in the frame after the next latch.
- Shallow line (2,1)-(14,4) → rows 1–4 each hit one contiguous span; spans are disjoint and their union is exactly x 2..14 (13 hits); reset pulse mid-frame → zero hits until after the next latch.
- LINE_THICK_EN defined, line (0,3)-(0,5) → rows 3–5 hit x 0..1 (lower end clamped).
